// File: rtl/fifo_stream_reader_if.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader_if
//
// Bundles the signals between the FIFO stream reader, the FIFO read port and
// the downstream consumer.
//
//   enable       reader may issue FIFO reads
//   fifo_empty   FIFO empty flag (registered inside the FIFO)
//   read_enable  FIFO pop request from the reader
//   fifo_data    FIFO read data, valid the cycle after read_enable
//   out_valid    stream word present
//   out_data     stream word (head of the reader's buffer)
//   out_last     stream word closes a frame
//   out_ready    consumer accepts the stream word
//   words_sent   running count of completed stream transfers
//
// Modports:
//   master  the reader itself
//   slave   the environment around it (FIFO plus consumer)
// ---------------------------------------------------------------------------
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
);

  logic                   enable;
  logic                   fifo_empty;
  logic                   read_enable;
  logic [DATA_WIDTH-1:0]  fifo_data;
  logic                   out_valid;
  logic [DATA_WIDTH-1:0]  out_data;
  logic                   out_last;
  logic                   out_ready;
  logic [COUNT_WIDTH-1:0] words_sent;

  modport master (
    input  enable,
    input  fifo_empty,
    input  fifo_data,
    input  out_ready,
    output read_enable,
    output out_valid,
    output out_data,
    output out_last,
    output words_sent
  );

  modport slave (
    output enable,
    output fifo_empty,
    output fifo_data,
    output out_ready,
    input  read_enable,
    input  out_valid,
    input  out_data,
    input  out_last,
    input  words_sent
  );

endinterface

// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
//
// Read-side controller for the FIFO queue. Pops words from the FIFO, soaks up
// the FIFO's one-cycle read latency in a 3-entry buffer, and presents the
// words as a valid/ready stream with frame delimiting and a delivered-word
// counter.
//
// Parameters:
//   DATA_WIDTH   width of FIFO words and stream data
//   FRAME_LEN    words per frame, 1..65535
//   COUNT_WIDTH  width of the words_sent counter
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      fifo_stream_reader_if.master: FIFO read port plus output stream
// ---------------------------------------------------------------------------
module fifo_stream_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int FRAME_LEN   = 4,
  parameter int COUNT_WIDTH = 16
) (
  input logic                  clk,
  input logic                  reset_n,
  fifo_stream_reader_if.master bus
);

  localparam logic [15:0]            LastIdx  = 16'(FRAME_LEN - 1);
  localparam logic [COUNT_WIDTH-1:0] CountOne = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0]  slots_q [3];
  logic [DATA_WIDTH-1:0]  slots_d [3];
  logic [1:0]             occ_q;
  logic [1:0]             occ_d;
  logic                   inflight_q;
  logic                   armed_q;
  logic [15:0]            frameCnt_q;
  logic [15:0]            frameCnt_d;
  logic [COUNT_WIDTH-1:0] wordsSent_q;
  logic [COUNT_WIDTH-1:0] wordsSent_d;

  logic                   readEnable;
  logic                   outValid;
  logic                   transfer;
  logic [2:0]             pending;
  logic [1:0]             occAfterPop;

  // Reads are only issued while the buffer can still absorb every word that
  // is buffered or already on its way back from the FIFO. Only registered
  // state feeds this, so the consumer's ready never reaches the FIFO port.
  // armed_q keeps reads off until the first edge after reset, by which time
  // the FIFO (reset alongside us) reports empty anyway.
  assign pending    = {1'b0, occ_q} + {2'b00, inflight_q};
  assign readEnable = armed_q && bus.enable && !bus.fifo_empty && (pending < 3'd3);
  assign outValid   = (occ_q != 2'd0);
  assign transfer   = outValid && bus.out_ready;

  assign bus.read_enable = readEnable;
  assign bus.out_valid   = outValid;
  assign bus.out_data    = slots_q[0];
  assign bus.out_last    = outValid && (frameCnt_q == LastIdx);
  assign bus.words_sent  = wordsSent_q;

  // Buffer next-state. Slot 0 is always the head, so a pop shifts the
  // entries down by one and a capture lands just behind the last word that
  // survives the pop. When the pop empties the buffer, slot 0 is left alone
  // so out_data keeps showing the last word that went out. A capture never
  // targets slot 3: a word is in flight only when occupancy is at most 2.
  always_comb begin
    slots_d[0]  = slots_q[0];
    slots_d[1]  = slots_q[1];
    slots_d[2]  = slots_q[2];
    occAfterPop = occ_q - {1'b0, transfer};

    if (transfer) begin
      if (occ_q > 2'd1) begin
        slots_d[0] = slots_q[1];
      end
      slots_d[1] = slots_q[2];
    end

    if (inflight_q) begin
      case (occAfterPop)
        2'd0:    slots_d[0] = bus.fifo_data;
        2'd1:    slots_d[1] = bus.fifo_data;
        default: slots_d[2] = bus.fifo_data;
      endcase
    end

    occ_d = occAfterPop + {1'b0, inflight_q};
  end

  // Frame position and delivered-word count both advance once per transfer.
  // The frame position wraps right after the word that carried out_last, and
  // the word count simply rolls over at its width.
  always_comb begin
    frameCnt_d  = frameCnt_q;
    wordsSent_d = wordsSent_q;
    if (transfer) begin
      wordsSent_d = wordsSent_q + CountOne;
      if (frameCnt_q == LastIdx) begin
        frameCnt_d = '0;
      end else begin
        frameCnt_d = frameCnt_q + 16'd1;
      end
    end
  end

  // State registers. Reset throws away buffered and in-flight words; the FIFO
  // is reset on the same line, so nothing it popped is left stranded. The
  // buffer slots are cleared too so out_data reads zero straight after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        slots_q[i] <= '0;
      end
      occ_q       <= 2'd0;
      inflight_q  <= 1'b0;
      armed_q     <= 1'b0;
      frameCnt_q  <= 16'd0;
      wordsSent_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        slots_q[i] <= slots_d[i];
      end
      occ_q       <= occ_d;
      inflight_q  <= readEnable;
      armed_q     <= 1'b1;
      frameCnt_q  <= frameCnt_d;
      wordsSent_q <= wordsSent_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_stream_reader
//
// Self-checking bench for fifo_stream_reader. Instance A uses the default
// parameters (8-bit data, 4-word frames, 16-bit counter); instance B uses
// 3-word frames and a 4-bit counter for the wrap case. Each instance gets a
// small behavioural FIFO with a registered empty flag and one-cycle read data.
// ---------------------------------------------------------------------------
module tb_fifo_stream_reader;

  typedef struct {
    int          preload;
    logic        en;
    logic        rdy;
    logic        expRe;
    logic        expValid;
    logic [7:0]  expData;
    logic        expLast;
    logic [15:0] expWords;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  int checks = 0;
  int errors = 0;
  int resetsSeen = 0;

  logic [7:0] qA [$];
  logic [7:0] qB [$];
  logic [7:0] gotDataA [$];
  logic       gotLastA [$];
  logic [7:0] gotDataB [$];
  logic       gotLastB [$];
  logic [3:0] gotWordsB [$];

  int reCountA = 0;
  int reWhileEmptyA = 0;
  int reWhileEmptyB = 0;
  int holdViolA = 0;
  int holdViolB = 0;
  int underflowA = 0;
  int underflowB = 0;
  int lastResetsA = 0;
  int lastResetsB = 0;
  logic       prevValidA = 1'b0;
  logic       prevReadyA = 1'b0;
  logic [7:0] prevDataA = 8'h00;
  logic       prevLastA = 1'b0;
  logic       prevValidB = 1'b0;
  logic       prevReadyB = 1'b0;
  logic [7:0] prevDataB = 8'h00;
  logic       prevLastB = 1'b0;

  vec_t vecs [30];

  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) busA ();
  fifo_stream_reader_if #(.DATA_WIDTH(8), .COUNT_WIDTH(4))  busB ();

  fifo_stream_reader #(.DATA_WIDTH(8), .FRAME_LEN(4), .COUNT_WIDTH(16)) dutA (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (busA)
  );

  fifo_stream_reader #(.DATA_WIDTH(8), .FRAME_LEN(3), .COUNT_WIDTH(4)) dutB (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (busB)
  );

  // FIFO model for instance A: pop on read_enable, data one cycle later,
  // empty flag registered from the occupancy after this edge's pop.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      qA.delete();
      busA.fifo_empty <= 1'b1;
      busA.fifo_data  <= 8'h00;
    end else begin
      if (busA.read_enable) begin
        if (qA.size() > 0) busA.fifo_data <= qA.pop_front();
        else underflowA++;
      end
      busA.fifo_empty <= (qA.size() == 0);
    end
  end

  // FIFO model for instance B, same behaviour.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      qB.delete();
      busB.fifo_empty <= 1'b1;
      busB.fifo_data  <= 8'h00;
    end else begin
      if (busB.read_enable) begin
        if (qB.size() > 0) busB.fifo_data <= qB.pop_front();
        else underflowB++;
      end
      busB.fifo_empty <= (qB.size() == 0);
    end
  end

  // Stream monitor for A: logs transfers, read pulses, reads against an
  // empty FIFO, and any change of a stalled word before it is accepted.
  always @(negedge clk) begin
    if (!reset_n) begin
      prevValidA = 1'b0;
    end else begin
      if (busA.read_enable) reCountA++;
      if (busA.read_enable && busA.fifo_empty) reWhileEmptyA++;
      if (resetsSeen != lastResetsA) lastResetsA = resetsSeen;
      else if (prevValidA && !prevReadyA &&
               (!busA.out_valid || busA.out_data !== prevDataA || busA.out_last !== prevLastA))
        holdViolA++;
      if (busA.out_valid && busA.out_ready) begin
        gotDataA.push_back(busA.out_data);
        gotLastA.push_back(busA.out_last);
      end
      prevValidA = busA.out_valid;
      prevReadyA = busA.out_ready;
      prevDataA  = busA.out_data;
      prevLastA  = busA.out_last;
    end
  end

  // Stream monitor for B, also logging the counter value at each transfer.
  always @(negedge clk) begin
    if (!reset_n) begin
      prevValidB = 1'b0;
    end else begin
      if (busB.read_enable && busB.fifo_empty) reWhileEmptyB++;
      if (resetsSeen != lastResetsB) lastResetsB = resetsSeen;
      else if (prevValidB && !prevReadyB &&
               (!busB.out_valid || busB.out_data !== prevDataB || busB.out_last !== prevLastB))
        holdViolB++;
      if (busB.out_valid && busB.out_ready) begin
        gotDataB.push_back(busB.out_data);
        gotLastB.push_back(busB.out_last);
        gotWordsB.push_back(busB.words_sent);
      end
      prevValidB = busB.out_valid;
      prevReadyB = busB.out_ready;
      prevDataB  = busB.out_data;
      prevLastB  = busB.out_last;
    end
  end

  // Drive instance A's inputs just after a rising edge.
  task automatic applyStimulus(input logic en, input logic rdy);
    @(posedge clk);
    #1;
    busA.enable    = en;
    busA.out_ready = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic pushA(input int n, input logic [7:0] first);
    for (int k = 0; k < n; k++) qA.push_back(first + 8'(k));
  endtask

  initial begin
    int reBase;
    int nBase;

    // Basic stream: 8 words, consumer always ready, frames of 4.
    vecs[0]  = '{8, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
    vecs[1]  = '{0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
    vecs[2]  = '{0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 16'd0};
    vecs[3]  = '{0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 1'b0, 16'd1};
    vecs[4]  = '{0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 16'd2};
    vecs[5]  = '{0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h04, 1'b1, 16'd3};
    vecs[6]  = '{0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 1'b0, 16'd4};
    vecs[7]  = '{0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h06, 1'b0, 16'd5};
    vecs[8]  = '{0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 16'd6};
    vecs[9]  = '{0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h08, 1'b1, 16'd7};
    vecs[10] = '{0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h08, 1'b0, 16'd8};
    // Stall: 8 words, ready low for 10 cycles; three reads then hold.
    vecs[11] = '{8, 1'b1, 1'b0, 1'b1, 1'b0, 8'h08, 1'b0, 16'd8};
    vecs[12] = '{0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h08, 1'b0, 16'd8};
    vecs[13] = '{0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 16'd8};
    for (int i = 14; i <= 20; i++)
      vecs[i] = '{0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 16'd8};
    vecs[21] = '{0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 16'd8};
    vecs[22] = '{0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 1'b0, 16'd9};
    vecs[23] = '{0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 16'd10};
    vecs[24] = '{0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h04, 1'b1, 16'd11};
    vecs[25] = '{0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 1'b0, 16'd12};
    vecs[26] = '{0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h06, 1'b0, 16'd13};
    vecs[27] = '{0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 16'd14};
    vecs[28] = '{0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h08, 1'b1, 16'd15};
    vecs[29] = '{0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h08, 1'b0, 16'd16};

    busA.enable    = 1'b0;
    busA.out_ready = 1'b0;
    busB.enable    = 1'b0;
    busB.out_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstA_re", 32'(busA.read_enable), 32'd0);
    checkOutput("rstA_valid", 32'(busA.out_valid), 32'd0);
    checkOutput("rstA_last", 32'(busA.out_last), 32'd0);
    checkOutput("rstA_data", 32'(busA.out_data), 32'd0);
    checkOutput("rstA_words", 32'(busA.words_sent), 32'd0);
    checkOutput("rstB_valid", 32'(busB.out_valid), 32'd0);
    checkOutput("rstB_words", 32'(busB.words_sent), 32'd0);
    reset_n = 1'b1;

    // Table-driven basic stream and stall.
    for (int i = 0; i < 30; i++) begin
      if (vecs[i].preload > 0) begin
        applyStimulus(1'b0, vecs[i].rdy);
        pushA(vecs[i].preload, 8'h01);
      end
      applyStimulus(vecs[i].en, vecs[i].rdy);
      @(negedge clk);
      checkOutput($sformatf("row%0d_re", i), 32'(busA.read_enable), 32'(vecs[i].expRe));
      checkOutput($sformatf("row%0d_valid", i), 32'(busA.out_valid), 32'(vecs[i].expValid));
      checkOutput($sformatf("row%0d_data", i), 32'(busA.out_data), 32'(vecs[i].expData));
      checkOutput($sformatf("row%0d_last", i), 32'(busA.out_last), 32'(vecs[i].expLast));
      checkOutput($sformatf("row%0d_words", i), 32'(busA.words_sent), 32'(vecs[i].expWords));
    end

    // Empty boundary: a single word, one read, one transfer.
    reBase = reCountA;
    nBase  = gotDataA.size();
    @(posedge clk);
    #1;
    pushA(1, 8'h55);
    repeat (8) @(negedge clk);
    checkOutput("empty_re_pulses", 32'(reCountA - reBase), 32'd1);
    checkOutput("empty_xfers", 32'(gotDataA.size() - nBase), 32'd1);
    checkOutput("empty_word", (gotDataA.size() > nBase) ? 32'(gotDataA[nBase]) : 32'hDEAD, 32'h55);
    checkOutput("empty_valid_after", 32'(busA.out_valid), 32'd0);
    checkOutput("empty_words", 32'(busA.words_sent), 32'd17);

    // Disable mid-stream: enable drops right after the second read.
    reBase = reCountA;
    nBase  = gotDataA.size();
    applyStimulus(1'b0, 1'b0);
    pushA(4, 8'h61);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("dis_re_low", 32'(busA.read_enable), 32'd0);
    repeat (3) applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("dis_hold_valid", 32'(busA.out_valid), 32'd1);
    checkOutput("dis_hold_data", 32'(busA.out_data), 32'h61);
    applyStimulus(1'b0, 1'b1);
    repeat (6) @(negedge clk);
    checkOutput("dis_re_pulses", 32'(reCountA - reBase), 32'd2);
    checkOutput("dis_xfers", 32'(gotDataA.size() - nBase), 32'd2);
    checkOutput("dis_word0", (gotDataA.size() > nBase) ? 32'(gotDataA[nBase]) : 32'hDEAD, 32'h61);
    checkOutput("dis_word1", (gotDataA.size() > nBase + 1) ? 32'(gotDataA[nBase + 1]) : 32'hDEAD, 32'h62);
    checkOutput("dis_valid_after", 32'(busA.out_valid), 32'd0);
    checkOutput("dis_words", 32'(busA.words_sent), 32'd19);

    // Asynchronous reset with two words buffered and one in flight.
    applyStimulus(1'b0, 1'b0);
    pushA(3, 8'h71);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("arst_pre_valid", 32'(busA.out_valid), 32'd1);
    checkOutput("arst_pre_data", 32'(busA.out_data), 32'h63);
    checkOutput("arst_pre_re", 32'(busA.read_enable), 32'd0);
    nBase = gotDataA.size();
    resetsSeen++;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(busA.out_valid), 32'd0);
    checkOutput("arst_re", 32'(busA.read_enable), 32'd0);
    checkOutput("arst_last", 32'(busA.out_last), 32'd0);
    checkOutput("arst_words", 32'(busA.words_sent), 32'd0);
    checkOutput("arst_data", 32'(busA.out_data), 32'd0);
    #1;
    reset_n = 1'b1;
    busA.out_ready = 1'b1;
    pushA(4, 8'hA0);
    for (int c = 0; c < 20 && gotDataA.size() < nBase + 4; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    checkOutput("arst_xfers", 32'(gotDataA.size() - nBase), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (gotDataA.size() > nBase + i) begin
        checkOutput($sformatf("arst_word%0d", i), 32'(gotDataA[nBase + i]), 32'hA0 + 32'(i));
        checkOutput($sformatf("arst_last%0d", i), 32'(gotLastA[nBase + i]), (i == 3) ? 32'd1 : 32'd0);
      end
    end
    checkOutput("arst_words_after", 32'(busA.words_sent), 32'd4);

    // Counter and frame wrap on instance B: 17 transfers, 3-word frames.
    @(posedge clk);
    #1;
    for (int k = 1; k <= 17; k++) qB.push_back(8'(k));
    busB.enable    = 1'b1;
    busB.out_ready = 1'b1;
    for (int c = 0; c < 60 && gotDataB.size() < 17; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    checkOutput("wrap_xfers", 32'(gotDataB.size()), 32'd17);
    for (int i = 0; i < 17; i++) begin
      if (i < gotDataB.size()) begin
        checkOutput($sformatf("wrap_data%0d", i + 1), 32'(gotDataB[i]), 32'(i + 1));
        checkOutput($sformatf("wrap_last%0d", i + 1), 32'(gotLastB[i]), ((i + 1) % 3 == 0) ? 32'd1 : 32'd0);
        checkOutput($sformatf("wrap_cnt%0d", i + 1), 32'(gotWordsB[i]), 32'(i % 16));
      end
    end
    checkOutput("wrap_words_after", 32'(busB.words_sent), 32'd1);
    checkOutput("wrap_valid_after", 32'(busB.out_valid), 32'd0);

    // Invariants gathered by the monitors over the whole run.
    checkOutput("A_read_while_empty", 32'(reWhileEmptyA), 32'd0);
    checkOutput("A_hold_violations", 32'(holdViolA), 32'd0);
    checkOutput("A_fifo_underflow", 32'(underflowA), 32'd0);
    checkOutput("B_read_while_empty", 32'(reWhileEmptyB), 32'd0);
    checkOutput("B_hold_violations", 32'(holdViolB), 32'd0);
    checkOutput("B_fifo_underflow", 32'(underflowB), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side controller for the team's FIFO queue. It pops words from the FIFO, absorbs the FIFO's one-cycle read latency in a 3-entry output buffer, and presents the words on a valid/ready stream with frame delimiting and a delivered-word counter. It sits between the FIFO's read port and any downstream consumer that can stall.

## Interface
- data_width, 8, width of FIFO words and stream data
- frame_len, 4, words per frame; out_last marks the final word; legal range 1..65535
- count_width, 16, width of the words_sent counter
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  when high, the block may issue FIFO reads
- fifo_empty  in  1  FIFO empty flag; registered in the FIFO
- read_enable  out  1  FIFO pop request; the FIFO's write_enable is held low by the system in any cycle this is high
- fifo_data  in  data_width  FIFO read data; valid in the cycle after read_enable was high
- out_valid  out  1  out_data holds a word
- out_data  out  data_width  head word of the buffer
- out_last  out  1  the head word is the last of a frame; qualified by out_valid
- out_ready  in  1  consumer accepts the word
- words_sent  out  count_width  running count of completed transfers

## Operation
- State:
  - buffer: 3 entries, FIFO order, occupancy occ from 0 to 3
  - inflight: 1 bit, set when a read was issued in the previous cycle
  - frame_cnt: 0..frame_len-1
  - words_sent
- Read issue (combinational): read_enable = enable && !fifo_empty && (occ + inflight < 3). It uses registered state only and never depends on out_ready.
- Capture: when inflight is 1, fifo_data is written into the buffer tail on that edge. inflight takes the value of read_enable on every edge.
- Transfer: occurs when out_valid && out_ready. The head word is popped.
- A capture and a transfer in the same cycle are both performed, and occ is unchanged.
- out_valid = (occ != 0). out_data is the head entry. When occ = 0, out_data holds its last value.
- out_last = out_valid && (frame_cnt == frame_len-1).
- frame_cnt increments on each transfer. It wraps to 0 after the word that had out_last high. With frame_len = 1, out_last is high on every word.
- words_sent increments on each transfer and wraps modulo 2^count_width.
- Once out_valid is high, out_data and out_last hold stable until a transfer occurs.
- enable low: no new reads are issued. A read already in flight is still captured, and buffered words are still delivered.
- Overflow is impossible by construction: occ + inflight never exceeds 3.
- Reset, asynchronous:
  - occ = 0, inflight = 0, frame_cnt = 0, words_sent = 0
  - read_enable = 0, out_valid = 0, out_last = 0, out_data = 0
- Reset during operation: the buffer and any in-flight word are discarded. The FIFO is reset on the same reset_n, so no word is orphaned.

## Timing
- Read-to-output latency: read_enable high in cycle N, fifo_data captured at the end of cycle N+1, out_valid high in cycle N+2.
- First-word latency: fifo_empty falls in cycle N with the buffer empty and enable high. read_enable is high in cycle N and out_valid is high in cycle N+2.
- Throughput: 1 word per cycle sustained while out_ready = 1 and fifo_empty = 0. Steady state is occ = 1, inflight = 1.
- Backpressure: with out_ready low, at most 3 words are popped beyond those delivered. read_enable drops in the cycle after occ + inflight reaches 3.
- Resume: read_enable may re-assert in the cycle after the first transfer that brings occ + inflight below 3.

## Test plan
- Basic stream:
  - Stimulus: FIFO preloaded with 0x01..0x08, enable = 1, out_ready = 1.
  - Response: words 0x01..0x08 appear on consecutive cycles starting 2 cycles after the first read_enable. out_last is high on 0x04 and 0x08. words_sent = 8.
- Stall:
  - Stimulus: FIFO holds 8 words, out_ready = 0 for 10 cycles, then 1.
  - Response: exactly 3 read_enable pulses during the stall, out_data holds 0x01, no word is lost or duplicated, and all 8 words follow in order.
- Empty boundary:
  - Stimulus: FIFO holds 1 word.
  - Response: one read_enable pulse, one transfer, then out_valid = 0. read_enable never asserts while fifo_empty = 1.
- Disable mid-stream:
  - Stimulus: enable drops in the same cycle a read is issued.
  - Response: that word is still delivered and no further read_enable occurs. The remaining buffered words drain.
- Counter and frame wrap:
  - Stimulus: count_width = 4, frame_len = 3, 17 transfers.
  - Response: words_sent reads 1 after the 17th transfer. out_last is high on transfers 3, 6, 9, 12 and 15.
- Asynchronous reset:
  - Stimulus: reset_n pulsed low mid-cycle with occ = 2 and a read in flight.
  - Response: out_valid, read_enable, out_last and words_sent are 0 immediately. After release with the FIFO refilled with 0xA0, the first word out is 0xA0 with frame_cnt restarted.
